hazard_ctrl: RTL and testbench

//  Consumer side of the pipeline-register hazard tags (A2/A3/Tnew) that regE/regM/regW carry.

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Purpose: pipeline hazard control: forwarding selects, D-stage stall and MD-unit busy countdown.
// Latency: forwarding selects and stall are combinational; md_busy is the registered countdown state.
// Backpressure: stall freezes PC/regD and bubbles regE; HI/LO users wait while the MD unit counts down.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rsD, rtD             D-stage source registers; tuse_rs/tuse_rt give their Tuse (7 = unused)
//   md_useD              D instruction touches the MD unit (mult/div/mfhi/mflo/mthi/mtlo)
//   rsE, rtE             E-stage source registers
//   A3E/TnewE, A3M/TnewM E and M destination tags; A3W is the W destination (Tnew 0 at W)
//   rtM                  M-stage rt register (store data)
//   md_start, md_div     E instruction launches the MD unit this cycle; md_div picks div latency
//   stall, md_busy       hazard stall and MD-unit-busy flag
//   fwd_rsD/rtD/rsE/rtE  2-bit selects: 0 = regfile/pipe, 1 = E, 2 = M, 3 = W
//   fwd_rtM              1 = take W write data for the M rt operand
//   stall_cnt            only with HAZARD_STAT_EN defined: saturating count of stalled cycles
//
// Optional feature macro: HAZARD_STAT_EN

module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [2:0]  tuse_rs,
    input  logic [2:0]  tuse_rt,
    input  logic        md_useD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  A3E,
    input  logic [2:0]  TnewE,
    input  logic [4:0]  rtM,
    input  logic [4:0]  A3M,
    input  logic [2:0]  TnewM,
    input  logic [4:0]  A3W,
    input  logic        md_start,
    input  logic        md_div,
    output logic        stall,
    output logic        md_busy,
`ifdef HAZARD_STAT_EN
    output logic [31:0] stall_cnt,
`endif
    output logic [1:0]  fwd_rsD,
    output logic [1:0]  fwd_rtD,
    output logic [1:0]  fwd_rsE,
    output logic [1:0]  fwd_rtE,
    output logic        fwd_rtM
);

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_E  = 2'd1;
    localparam logic [1:0] SEL_M  = 2'd2;
    localparam logic [1:0] SEL_W  = 2'd3;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    // A stage can only supply a value once its result exists (Tnew == 0).
    // $zero is never a real destination, so a zero tag matches nothing.
    logic e_ready;
    logic m_ready;
    logic w_valid;

    assign e_ready = (A3E != 5'd0) && (TnewE == 3'd0);
    assign m_ready = (A3M != 5'd0) && (TnewM == 3'd0);
    assign w_valid = (A3W != 5'd0);

    // ------------------------------------------------------------------
    // Forwarding selects; the nearest producing stage wins.
    // ------------------------------------------------------------------
    always_comb begin
        fwd_rsD = SEL_RF;
        if (e_ready && (A3E == rsD))      fwd_rsD = SEL_E;
        else if (m_ready && (A3M == rsD)) fwd_rsD = SEL_M;
        else if (w_valid && (A3W == rsD)) fwd_rsD = SEL_W;
    end

    always_comb begin
        fwd_rtD = SEL_RF;
        if (e_ready && (A3E == rtD))      fwd_rtD = SEL_E;
        else if (m_ready && (A3M == rtD)) fwd_rtD = SEL_M;
        else if (w_valid && (A3W == rtD)) fwd_rtD = SEL_W;
    end

    always_comb begin
        fwd_rsE = SEL_RF;
        if (m_ready && (A3M == rsE))      fwd_rsE = SEL_M;
        else if (w_valid && (A3W == rsE)) fwd_rsE = SEL_W;
    end

    always_comb begin
        fwd_rtE = SEL_RF;
        if (m_ready && (A3M == rtE))      fwd_rtE = SEL_M;
        else if (w_valid && (A3W == rtE)) fwd_rtE = SEL_W;
    end

    assign fwd_rtM = w_valid && (A3W == rtM);

    // ------------------------------------------------------------------
    // Data stall: a later stage will write the source, but not before the
    // D instruction needs it (Tnew > Tuse). Tuse 7 can never be exceeded
    // because Tnew tops out at 3, so unused sources drop out naturally.
    // ------------------------------------------------------------------
    logic stall_rs_e;
    logic stall_rs_m;
    logic stall_rt_e;
    logic stall_rt_m;
    logic data_stall;

    assign stall_rs_e = (A3E != 5'd0) && (A3E == rsD) && (TnewE > tuse_rs);
    assign stall_rs_m = (A3M != 5'd0) && (A3M == rsD) && (TnewM > tuse_rs);
    assign stall_rt_e = (A3E != 5'd0) && (A3E == rtD) && (TnewE > tuse_rt);
    assign stall_rt_m = (A3M != 5'd0) && (A3M == rtD) && (TnewM > tuse_rt);

    assign data_stall = stall_rs_e | stall_rs_m | stall_rt_e | stall_rt_m;

    // ------------------------------------------------------------------
    // MD unit countdown. md_start covers the launch cycle itself, the
    // counter covers the remaining busy cycles.
    // ------------------------------------------------------------------
    logic [3:0] md_cnt;
    logic       md_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt <= 4'd0;
        end else if (md_start) begin
            md_cnt <= md_div ? DIV_CNT : MULT_CNT;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

    assign md_busy  = (md_cnt != 4'd0);
    assign md_stall = md_useD && (md_busy || md_start);

    assign stall = data_stall || md_stall;

`ifdef HAZARD_STAT_EN
    // ------------------------------------------------------------------
    // Stall statistics: saturating count of stalled cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  rsD, rtD, rsE, rtE, rtM, A3E, A3M, A3W;
    logic [2:0]  tuse_rs, tuse_rt, TnewE, TnewM;
    logic        md_useD, md_start, md_div;
    logic        stall, md_busy, fwd_rtM;
    logic [1:0]  fwd_rsD, fwd_rtD, fwd_rsE, fwd_rtE;
`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
        .md_useD(md_useD), .rsE(rsE), .rtE(rtE),
        .A3E(A3E), .TnewE(TnewE), .rtM(rtM), .A3M(A3M), .TnewM(TnewM),
        .A3W(A3W), .md_start(md_start), .md_div(md_div),
        .stall(stall), .md_busy(md_busy),
`ifdef HAZARD_STAT_EN
        .stall_cnt(stall_cnt),
`endif
        .fwd_rsD(fwd_rsD), .fwd_rtD(fwd_rtD), .fwd_rsE(fwd_rsE),
        .fwd_rtE(fwd_rtE), .fwd_rtM(fwd_rtM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining busy cycles of the MD unit and stall count.
    int          md_rem  = 0;
    longint      stat_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stage index: 1 = E, 2 = M, 3 = W. Returns nearest stage (from first..3) whose
    // ready result targets register x, or 0 if none.
    function automatic int nearest_src(input logic [4:0] x, input int first);
        int dst [1:3];
        int tn  [1:3];
        dst[1] = A3E; dst[2] = A3M; dst[3] = A3W;
        tn[1]  = TnewE; tn[2] = TnewM; tn[3] = 0;
        for (int s = first; s <= 3; s++)
            if (x != 0 && dst[s] == x && tn[s] == 0) return s;
        return 0;
    endfunction

    function automatic bit needs_stall(input logic [4:0] x, input int tuse);
        int dst [1:2];
        int tn  [1:2];
        dst[1] = A3E; dst[2] = A3M;
        tn[1]  = TnewE; tn[2] = TnewM;
        for (int s = 1; s <= 2; s++)
            if (x != 0 && dst[s] == x && tn[s] > tuse) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall();
        bit busy;
        busy = (md_rem != 0);
        return needs_stall(rsD, tuse_rs) || needs_stall(rtD, tuse_rt) ||
               (md_useD && (busy || md_start));
    endfunction

    // Sample at negedge, compare everything against the model, then advance the
    // model across the coming posedge (inputs hold until then).
    task automatic sample();
        bit exp_stall;
        @(negedge clk);
        exp_stall = model_stall();
        chk("stall",   stall,   exp_stall);
        chk("md_busy", md_busy, md_rem != 0);
        chk("fwd_rsD", fwd_rsD, nearest_src(rsD, 1));
        chk("fwd_rtD", fwd_rtD, nearest_src(rtD, 1));
        chk("fwd_rsE", fwd_rsE, nearest_src(rsE, 2));
        chk("fwd_rtE", fwd_rtE, nearest_src(rtE, 2));
        chk("fwd_rtM", fwd_rtM, nearest_src(rtM, 3) == 3);
`ifdef HAZARD_STAT_EN
        chk("stall_cnt", stall_cnt, stat_cnt);
`endif
        if (rst) begin
            md_rem   = 0;
            stat_cnt = 0;
        end else begin
            if (exp_stall && stat_cnt != 64'hFFFF_FFFF) stat_cnt++;
            if (md_start)        md_rem = md_div ? 10 : 5;
            else if (md_rem > 0) md_rem--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; rtM = 0;
        A3E = 0; A3M = 0; A3W = 0; TnewE = 0; TnewM = 0;
        tuse_rs = 7; tuse_rt = 7;
        md_useD = 0; md_start = 0; md_div = 0;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd3;
            default: return 5'd31;
        endcase
    endfunction

    function automatic logic [2:0] pick_tuse();
        case ($urandom_range(0, 3))
            0: return 3'd0;
            1: return 3'd1;
            2: return 3'd2;
            default: return 3'd7;
        endcase
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        #1;

        // Reset state, all tags zero.
        sample();
        tick();
        rst = 1'b0;
        sample();
        chk("reset_stall", stall, 0);
        chk("reset_busy", md_busy, 0);
        chk("reset_fwd_rsD", fwd_rsD, 0);
        chk("reset_fwd_rtE", fwd_rtE, 0);
        tick();

        // Load-use style stall in E, then the same producer in M.
        A3E = 5; TnewE = 2; rsD = 5; tuse_rs = 0;
        sample();
        chk("lit_stall_E", stall, 1);
        tick();
        A3E = 0; TnewE = 0; A3M = 5; TnewM = 1;
        sample();
        chk("lit_stall_M", stall, 1);
        tick();

        // E operand from M, and M still beats W.
        clear_inputs();
        A3M = 5; TnewM = 0; rsE = 5;
        sample();
        chk("lit_fwd_rsE_M", fwd_rsE, 2);
        tick();
        A3W = 5;
        sample();
        chk("lit_fwd_rsE_MW", fwd_rsE, 2);
        tick();

        // jal writing $31 ready in E.
        clear_inputs();
        A3E = 31; TnewE = 0; rsD = 31; tuse_rs = 0;
        sample();
        chk("lit_jal_fwd", fwd_rsD, 1);
        chk("lit_jal_stall", stall, 0);
        tick();

        // $zero never stalls or forwards.
        clear_inputs();
        A3E = 0; TnewE = 2; rsD = 0; tuse_rs = 0;
        sample();
        chk("lit_zero_stall", stall, 0);
        chk("lit_zero_fwd", fwd_rsD, 0);
        tick();

        // div followed by an MD user: 11 stalled cycles, then free.
        clear_inputs();
        md_start = 1; md_div = 1; md_useD = 1;
        sample();
        chk("lit_div_start_stall", stall, 1);
        tick();
        md_start = 0; md_div = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            chk("lit_div_busy_stall", stall, 1);
            tick();
        end
        sample();
        chk("lit_div_done_stall", stall, 0);
        chk("lit_div_done_busy", md_busy, 0);
        tick();

        // mult, then reset when the count reaches 4.
        clear_inputs();
        md_start = 1;
        sample();
        tick();
        md_start = 0;
        sample();          // count 5
        tick();
        rst = 1;
        sample();          // count 4, reset taking effect at the next edge
        chk("lit_cnt4_busy", md_busy, 1);
        tick();
        rst = 0;
        sample();
        chk("lit_rst_busy", md_busy, 0);
`ifdef HAZARD_STAT_EN
        chk("lit_rst_stall_cnt", stall_cnt, 0);
`endif
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rsD = pick_reg(); rtD = pick_reg();
            rsE = pick_reg(); rtE = pick_reg(); rtM = pick_reg();
            A3E = pick_reg(); A3M = pick_reg(); A3W = pick_reg();
            TnewE = 3'($urandom_range(0, 3));
            TnewM = 3'($urandom_range(0, 2));
            tuse_rs = pick_tuse(); tuse_rt = pick_tuse();
            md_useD = ($urandom_range(0, 2) == 0);
            md_start = (md_rem == 0) && ($urandom_range(0, 7) == 0);
            md_div = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            sample();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
